// File: rtl/cache_tag_write_ctrl.sv
// Write-port controller for a 4-way MOESI tag array: arbitrates snoop and core
// updates and sequences the LRU touch walk that rewrites a set one way per cycle.
module cache_tag_write_ctrl #(
   parameter int  SETS      = 128,
   parameter int  WAYS      = 4,
   parameter int  TAG_WIDTH = 19,
   parameter int  LRU_BITS  = 2,
   localparam int SET_W     = $clog2(SETS),
   localparam int WAY_W     = $clog2(WAYS)
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                core_valid,
   output logic                                core_ready,
   input  logic [SET_W-1:0]                    core_set,
   input  logic [WAY_W-1:0]                    core_way,
   input  logic [TAG_WIDTH-1:0]                core_tag,
   input  logic                                core_vld,
   input  logic [2:0]                          core_state,
   input  logic                                core_touch,
   output logic                                core_done,
   input  logic                                snp_valid,
   output logic                                snp_ready,
   input  logic [SET_W-1:0]                    snp_set,
   input  logic [WAY_W-1:0]                    snp_way,
   input  logic                                snp_vld,
   input  logic [2:0]                          snp_state,
   output logic [SET_W-1:0]                    rd_set,
   input  logic [WAYS-1:0][TAG_WIDTH-1:0]      rd_tags,
   input  logic [WAYS-1:0]                     rd_valids,
   input  logic [WAYS-1:0][2:0]                rd_states,
   input  logic [WAYS-1:0][LRU_BITS-1:0]       rd_lru,
   output logic                                wr_en,
   output logic [SET_W-1:0]                    wr_set,
   output logic [WAY_W-1:0]                    wr_way,
   output logic [TAG_WIDTH-1:0]                wr_tag,
   output logic                                wr_valid,
   output logic [2:0]                          wr_state,
   output logic [LRU_BITS-1:0]                 wr_lru,
   output logic                                busy
);

   // Handshake: a request transfers in any cycle where its valid and ready are
   // both high; ready is combinational from valid and is never high without it.
   typedef enum logic {ST_IDLE = 1'b0, ST_WALK = 1'b1} state_t;

   localparam logic [LRU_BITS-1:0] AGE_MAX  = {LRU_BITS{1'b1}};
   localparam logic [WAY_W-1:0]    LAST_WAY = WAY_W'(WAYS - 1);

   state_t                          state_q, state_d;
   logic [WAY_W-1:0]                cnt_q, cnt_d;
   logic                            done_q, done_d;
   logic [SET_W-1:0]                snap_set_q, snap_set_d;
   logic [WAY_W-1:0]                snap_way_q, snap_way_d;
   logic [TAG_WIDTH-1:0]            snap_tag_q, snap_tag_d;
   logic                            snap_vld_q, snap_vld_d;
   logic [2:0]                      snap_state_q, snap_state_d;
   logic [WAYS-1:0][TAG_WIDTH-1:0]  snap_tags_q, snap_tags_d;
   logic [WAYS-1:0]                 snap_valids_q, snap_valids_d;
   logic [WAYS-1:0][2:0]            snap_states_q, snap_states_d;
   logic [WAYS-1:0][LRU_BITS-1:0]   snap_lru_q, snap_lru_d;
   logic [LRU_BITS-1:0]             ref_age_q, ref_age_d;

   logic                            snp_wr, core_wr, walk_wr, touch_acc;
   logic [LRU_BITS-1:0]             walk_age, aged;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         done_q        <= 1'b0;
         snap_set_q    <= '0;
         snap_way_q    <= '0;
         snap_tag_q    <= '0;
         snap_vld_q    <= 1'b0;
         snap_state_q  <= '0;
         snap_tags_q   <= '0;
         snap_valids_q <= '0;
         snap_states_q <= '0;
         snap_lru_q    <= '0;
         ref_age_q     <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         done_q        <= done_d;
         snap_set_q    <= snap_set_d;
         snap_way_q    <= snap_way_d;
         snap_tag_q    <= snap_tag_d;
         snap_vld_q    <= snap_vld_d;
         snap_state_q  <= snap_state_d;
         snap_tags_q   <= snap_tags_d;
         snap_valids_q <= snap_valids_d;
         snap_states_q <= snap_states_d;
         snap_lru_q    <= snap_lru_d;
         ref_age_q     <= ref_age_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      done_d        = 1'b0;
      snap_set_d    = snap_set_q;
      snap_way_d    = snap_way_q;
      snap_tag_d    = snap_tag_q;
      snap_vld_d    = snap_vld_q;
      snap_state_d  = snap_state_q;
      snap_tags_d   = snap_tags_q;
      snap_valids_d = snap_valids_q;
      snap_states_d = snap_states_q;
      snap_lru_d    = snap_lru_q;
      ref_age_d     = ref_age_q;
      if (state_q == ST_IDLE) begin
         if (touch_acc) begin
            snap_set_d    = core_set;
            snap_way_d    = core_way;
            snap_tag_d    = core_tag;
            snap_vld_d    = core_vld;
            snap_state_d  = core_state;
            snap_tags_d   = rd_tags;
            snap_valids_d = rd_valids;
            snap_states_d = rd_states;
            snap_lru_d    = rd_lru;
            ref_age_d     = rd_lru[core_way];
            cnt_d         = '0;
            state_d       = ST_WALK;
         end
      end else if (walk_wr) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == LAST_WAY) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
         end
      end
   end

   always_comb begin
      snp_wr    = 1'b0;
      core_wr   = 1'b0;
      walk_wr   = 1'b0;
      touch_acc = 1'b0;
      rd_set    = snp_set;
      if (state_q == ST_IDLE && !snp_valid) rd_set = core_set;
      // Ways younger than the touched way age by one; older ones keep their age.
      walk_age = snap_lru_q[cnt_q];
      aged     = walk_age;
      if (walk_age < ref_age_q && walk_age != AGE_MAX) aged = walk_age + 1'b1;
      if (rst_n) begin
         if (state_q == ST_IDLE) begin
            if (snp_valid) snp_wr = 1'b1;
            else if (core_valid) begin
               if (core_touch) touch_acc = 1'b1;
               else            core_wr   = 1'b1;
            end
         end else if (snp_valid && snp_set != snap_set_q) begin
            snp_wr = 1'b1;
         end else begin
            walk_wr = 1'b1;
         end
      end
      snp_ready  = snp_wr;
      core_ready = core_wr | touch_acc;
      wr_set     = snp_set;
      wr_way     = snp_way;
      wr_tag     = rd_tags[snp_way];
      wr_valid   = snp_vld;
      wr_state   = snp_state;
      wr_lru     = rd_lru[snp_way];
      if (core_wr) begin
         wr_set   = core_set;
         wr_way   = core_way;
         wr_tag   = core_tag;
         wr_valid = core_vld;
         wr_state = core_state;
         wr_lru   = rd_lru[core_way];
      end else if (walk_wr) begin
         wr_set = snap_set_q;
         wr_way = cnt_q;
         if (cnt_q == snap_way_q) begin
            wr_tag   = snap_tag_q;
            wr_valid = snap_vld_q;
            wr_state = snap_state_q;
            wr_lru   = '0;
         end else begin
            wr_tag   = snap_tags_q[cnt_q];
            wr_valid = snap_valids_q[cnt_q];
            wr_state = snap_states_q[cnt_q];
            wr_lru   = aged;
         end
      end
      wr_en     = snp_wr | core_wr | walk_wr;
      busy      = (state_q == ST_WALK);
      core_done = done_q;
   end

endmodule

// File: tb/tb_cache_tag_write_ctrl.sv
// Self-checking bench for cache_tag_write_ctrl: tag-array memory model,
// directed scenarios, randomized transactions and a transaction-level reference.
module tb_cache_tag_write_ctrl;
   localparam int SETS = 128;
   localparam int WAYS = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic core_valid, core_ready, core_vld, core_touch, core_done;
   logic [6:0] core_set;
   logic [1:0] core_way;
   logic [18:0] core_tag;
   logic [2:0] core_state;
   logic snp_valid, snp_ready, snp_vld;
   logic [6:0] snp_set;
   logic [1:0] snp_way;
   logic [2:0] snp_state;
   logic [6:0] rd_set;
   logic [3:0][18:0] rd_tags;
   logic [3:0] rd_valids;
   logic [3:0][2:0] rd_states;
   logic [3:0][1:0] rd_lru;
   logic wr_en, wr_valid, busy;
   logic [6:0] wr_set;
   logic [1:0] wr_way;
   logic [18:0] wr_tag;
   logic [2:0] wr_state;
   logic [1:0] wr_lru;

   cache_tag_write_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .core_valid(core_valid), .core_ready(core_ready), .core_set(core_set),
      .core_way(core_way), .core_tag(core_tag), .core_vld(core_vld),
      .core_state(core_state), .core_touch(core_touch), .core_done(core_done),
      .snp_valid(snp_valid), .snp_ready(snp_ready), .snp_set(snp_set),
      .snp_way(snp_way), .snp_vld(snp_vld), .snp_state(snp_state),
      .rd_set(rd_set), .rd_tags(rd_tags), .rd_valids(rd_valids),
      .rd_states(rd_states), .rd_lru(rd_lru),
      .wr_en(wr_en), .wr_set(wr_set), .wr_way(wr_way), .wr_tag(wr_tag),
      .wr_valid(wr_valid), .wr_state(wr_state), .wr_lru(wr_lru), .busy(busy)
   );

   // Entry layout: {tag[24:6], valid[5], state[4:2], lru[1:0]}
   logic [24:0] mem   [SETS][WAYS];
   logic [24:0] exp_m [SETS][WAYS];
   logic [24:0] tn    [WAYS];
   logic        pre_en;
   logic [6:0]  pre_set;
   logic [1:0]  pre_way;
   logic [24:0] pre_ent;
   logic [33:0] exp_q[$];
   logic [33:0] mon_e;
   int n_cmp = 0;
   int n_err = 0;

   always_comb begin
      for (int w = 0; w < WAYS; w++) begin
         rd_tags[w]   = mem[rd_set][w][24:6];
         rd_valids[w] = mem[rd_set][w][5];
         rd_states[w] = mem[rd_set][w][4:2];
         rd_lru[w]    = mem[rd_set][w][1:0];
      end
   end

   always @(posedge clk) begin
      if (pre_en) mem[pre_set][pre_way] <= pre_ent;
      else if (wr_en) mem[wr_set][wr_way] <= {wr_tag, wr_valid, wr_state, wr_lru};
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Walk-write scoreboard: any write granted to neither requester is a walk write.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (rst_n && wr_en && !snp_ready && !core_ready) begin
            if (exp_q.size() == 0) chk("walk_unexpected", 64'(exp_q.size()), 64'd1);
            else begin
               mon_e = exp_q.pop_front();
               chk("walk_wr", {wr_set, wr_way, wr_tag, wr_valid, wr_state, wr_lru}, mon_e);
            end
         end
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic clr_in();
      core_valid = 0; core_set = 0; core_way = 0; core_tag = 0; core_vld = 0;
      core_state = 0; core_touch = 0; snp_valid = 0; snp_set = 0; snp_way = 0;
      snp_vld = 0; snp_state = 0; pre_en = 0; pre_set = 0; pre_way = 0; pre_ent = 0;
   endtask

   task automatic rand_snp(input int s);
      snp_valid = 1; snp_set = 7'(s); snp_way = 2'($urandom);
      snp_vld = 1'($urandom); snp_state = 3'($urandom_range(0, 4));
   endtask

   task automatic rand_core(input int s, input logic touch);
      core_valid = 1; core_set = 7'(s); core_way = 2'($urandom); core_tag = 19'($urandom);
      core_vld = 1'($urandom); core_state = 3'($urandom_range(0, 4)); core_touch = touch;
   endtask

   task automatic preload(input int s, input int w, input logic [24:0] e);
      tick(); clr_in();
      pre_en = 1; pre_set = 7'(s); pre_way = 2'(w); pre_ent = e;
      exp_m[s][w] = e;
   endtask

   task automatic check_snoop_wr(input string tag);
      logic [24:0] e;
      e = exp_m[snp_set][snp_way];
      chk({tag, "_rdy"}, {snp_ready, core_ready}, 2'b10);
      chk({tag, "_wr"}, {wr_en, wr_set, wr_way, wr_tag, wr_valid, wr_state, wr_lru},
          {1'b1, snp_set, snp_way, e[24:6], snp_vld, snp_state, e[1:0]});
      exp_m[snp_set][snp_way] = {e[24:6], snp_vld, snp_state, e[1:0]};
   endtask

   task automatic check_core_wr(input string tag);
      logic [24:0] e;
      e = exp_m[core_set][core_way];
      chk({tag, "_rdy"}, {snp_ready, core_ready}, 2'b01);
      chk({tag, "_wr"}, {wr_en, wr_set, wr_way, wr_tag, wr_valid, wr_state, wr_lru},
          {1'b1, core_set, core_way, core_tag, core_vld, core_state, e[1:0]});
      exp_m[core_set][core_way] = {core_tag, core_vld, core_state, e[1:0]};
   endtask

   // Reference aging rule computed from the model's current view of the set.
   task automatic calc_touch(input int s, input int w, input logic [18:0] t,
                             input logic v, input logic [2:0] st);
      int ref_age, age;
      ref_age = int'(exp_m[s][w][1:0]);
      for (int i = 0; i < WAYS; i++) begin
         age = int'(exp_m[s][i][1:0]);
         if (i == w) tn[i] = {t, v, st, 2'd0};
         else begin
            if (age < ref_age) age = (age + 1 > 3) ? 3 : age + 1;
            tn[i] = {exp_m[s][i][24:2], 2'(age)};
         end
      end
   endtask

   task automatic accept_touch(input int s, input int w, input logic [18:0] t,
                               input logic v, input logic [2:0] st, input int nw);
      tick(); clr_in();
      core_valid = 1; core_touch = 1; core_set = 7'(s); core_way = 2'(w);
      core_tag = t; core_vld = v; core_state = st;
      #1;
      chk("touch_acc", {core_ready, snp_ready, wr_en, busy}, 4'b1000);
      calc_touch(s, w, t, v, st);
      for (int i = 0; i < nw; i++) begin
         exp_q.push_back({7'(s), 2'(i), tn[i]});
         exp_m[s][i] = tn[i];
      end
   endtask

   // mode 0: no snoop; 1: one snoop to another set at cycle snp_cyc; 2: same-set snoop.
   task automatic touch(input int s, input int w, input logic [18:0] t, input logic v,
                        input logic [2:0] st, input int mode, input int snp_cyc, input int oset);
      int nbusy, npre, sw;
      bit fin;
      nbusy = 0; npre = 0; fin = 0; sw = $urandom_range(0, 3);
      accept_touch(s, w, t, v, st, WAYS);
      for (int c = 0; c < 20 && !fin; c++) begin
         tick(); clr_in();
         rand_core($urandom_range(0, 15), 1'b0);
         if (mode == 1 && c == snp_cyc)
            rand_snp(oset >= 0 ? oset : (s + 1 + $urandom_range(0, SETS - 2)) % SETS);
         if (mode == 2) begin
            rand_snp(s); snp_way = 2'(sw);
         end
         #1;
         if (busy) begin
            nbusy++;
            chk("walk_core_rdy", {core_ready, core_done}, 2'b00);
            if (mode == 1 && c == snp_cyc) begin
               check_snoop_wr("walk_preempt");
               npre++;
            end else chk("walk_snp_rdy", snp_ready, 0);
         end else begin
            fin = 1;
            chk("walk_done", core_done, 1);
            chk("walk_cycles", nbusy, WAYS + npre);
            chk("walk_q_empty", 64'(exp_q.size()), 0);
            if (snp_valid) check_snoop_wr("post_walk_snp");
            else check_core_wr("post_walk_core");
         end
      end
      if (!fin) chk("walk_timeout", fin, 1);
   endtask

   initial begin
      logic [1:0] age_exp [WAYS];
      logic [24:0] ent;
      clr_in();
      #1 rst_n = 0;
      for (int s = 0; s < SETS; s++) begin
         for (int w = 0; w < WAYS; w++) begin
            tick(); clr_in();
            core_valid = 1; core_touch = 1'($urandom); snp_valid = 1;
            ent = {19'($urandom), 1'($urandom), 3'($urandom_range(0, 4)), 2'($urandom)};
            pre_en = 1; pre_set = 7'(s); pre_way = 2'(w); pre_ent = ent;
            exp_m[s][w] = ent;
            #1;
            if (s == 0) chk("reset_outs", {wr_en, core_ready, snp_ready, busy, core_done}, 5'b0);
         end
      end
      tick(); clr_in(); rst_n = 1;
      #1 chk("idle_outs", {wr_en, core_ready, snp_ready, busy, core_done}, 5'b0);
      tick(); clr_in(); rand_core(3, 1'b0);
      #1 check_core_wr("first_core");

      // Touch set 5 way 2, ages {0,1,2,3}
      for (int w = 0; w < WAYS; w++) preload(5, w, {19'($urandom), 1'b1, 3'd3, 2'(w)});
      touch(5, 2, 19'h1ABCD, 1'b1, 3'b010, 0, 0, -1);
      age_exp = '{2'd1, 2'd2, 2'd0, 2'd3};
      for (int w = 0; w < WAYS; w++) chk("t1_age", mem[5][w][1:0], age_exp[w]);
      chk("t1_target", {mem[5][2][24:6], mem[5][2][4:2]}, {19'h1ABCD, 3'b010});

      // Simultaneous snoop and core to set 9
      tick(); clr_in(); rand_snp(9); snp_way = 1; rand_core(9, 1'b0); core_way = 3;
      #1 check_snoop_wr("sim_snp");
      tick(); snp_valid = 0;
      #1 check_core_wr("sim_core");

      touch(5, 1, 19'($urandom), 1'b1, 3'b011, 1, 1, 7);
      touch(5, 3, 19'($urandom), 1'b0, 3'b100, 2, 0, -1);

      // Reset mid-walk after two committed writes
      accept_touch(5, 0, 19'h0F0F0, 1'b1, 3'b000, 2);
      for (int c = 0; c < 2; c++) begin
         tick(); clr_in();
         #1 chk("rst_walk_busy", busy, 1);
      end
      tick(); clr_in(); core_valid = 1; rand_snp(11); rst_n = 0;
      #1 chk("rst_mid_walk", {wr_en, core_ready, snp_ready, busy, core_done}, 5'b0);
      exp_q.delete();
      tick(); clr_in();
      #1 chk("rst_hold_done", core_done, 0);
      tick(); clr_in(); rst_n = 1;
      #1 chk("rst_release", {wr_en, busy, core_done}, 3'b0);
      tick(); clr_in();
      #1 chk("rst_no_done", core_done, 0);
      for (int w = 0; w < WAYS; w++) chk("rst_set5", mem[5][w], exp_m[5][w]);

      for (int n = 0; n < 60; n++) begin
         int kind, s;
         kind = $urandom_range(0, 5);
         s = $urandom_range(0, 15);
         case (kind)
            0: begin tick(); clr_in(); rand_snp(s); #1 check_snoop_wr("rnd_snp"); end
            1: begin tick(); clr_in(); rand_core(s, 1'b0); #1 check_core_wr("rnd_core"); end
            5: begin
               tick(); clr_in(); rand_snp(s); rand_core(s, 1'($urandom));
               #1 check_snoop_wr("rnd_sim");
            end
            default: touch(s, $urandom_range(0, 3), 19'($urandom), 1'($urandom),
                           3'($urandom_range(0, 4)), kind - 2, $urandom_range(0, 3), -1);
         endcase
      end

      tick(); clr_in();
      tick();
      chk("final_q_empty", 64'(exp_q.size()), 0);
      for (int s = 0; s < SETS; s++)
         for (int w = 0; w < WAYS; w++) chk("final_array", mem[s][w], exp_m[s][w]);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
